// File: rtl/hh_neuron_array_if.sv
// Control, current-write and readout signals of the HH neuron array.
// The slave modport is the array; the master modport is whoever drives it.
interface hh_neuron_array_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                    start;
    logic signed [WIDTH-1:0] dt;
    logic                    cur_we;
    logic [AW-1:0]           cur_addr;
    logic signed [WIDTH-1:0] current_in;
    logic [AW-1:0]           rd_addr;
    logic signed [WIDTH-1:0] data_out;
    logic [CHANNELS-1:0]     spike_out;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, dt, cur_we, cur_addr, current_in, rd_addr,
        output data_out, spike_out, busy, done
    );

    modport master (
        output start, dt, cur_we, cur_addr, current_in, rd_addr,
        input  data_out, spike_out, busy, done
    );
endinterface

// File: rtl/hh_neuron_array.sv
// Time-multiplexed linear HH neuron array: one shared datapath, 2 cycles per channel (DV, UPD).
// A step takes 2*CHANNELS+1 cycles from start to done; start while busy is dropped.
module hh_neuron_array #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int CHANNELS  = 4,
    parameter int E_L       = -16640,
    parameter int V_TH      = -12800,
    parameter int V_RESET   = -17920,
    parameter int G_L       = 26,
    parameter int A         = 64,
    parameter int B         = 512,
    parameter int TAU_SHIFT = 4,
    parameter int REFRAC    = 2
) (
    input  logic             clock,
    input  logic             reset,
    hh_neuron_array_if.slave bus
);
    localparam int AW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NSLOT = 1 << AW;
    localparam int RCW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int XW    = 2 * WIDTH + 4;

    localparam logic signed [XW-1:0] SMAX = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DV, UPD, DONE} state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] v_q [NSLOT];
    logic signed [WIDTH-1:0] w_q [NSLOT];
    logic signed [WIDTH-1:0] i_q [NSLOT];
    logic [RCW-1:0]          rc_q [NSLOT];

    logic [AW-1:0]           ch_q;
    logic signed [WIDTH-1:0] dt_q;
    logic signed [WIDTH-1:0] dv_q;
    logic [CHANNELS-1:0]     spk_acc_q;
    logic [CHANNELS-1:0]     spike_q;
    logic signed [WIDTH-1:0] dout_q;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
        if (x > SMAX) return SMAX[WIDTH-1:0];
        if (x < SMIN) return SMIN[WIDTH-1:0];
        return x[WIDTH-1:0];
    endfunction

    logic                last_ch;
    logic                accept;
    logic                fire;
    logic [CHANNELS-1:0] spk_vec;

    logic signed [XW-1:0] v_x, w_x, i_x, dt_x, dvq_x, vdiff, leak, dv_raw, vn, coup, wn;

    assign last_ch = (ch_q == AW'(CHANNELS - 1));
    assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // All arithmetic is carried wide enough that only the final store can overflow.
    assign v_x    = XW'(v_q[ch_q]);
    assign w_x    = XW'(w_q[ch_q]);
    assign i_x    = XW'(i_q[ch_q]);
    assign dt_x   = XW'(dt_q);
    assign dvq_x  = XW'(dv_q);
    assign vdiff  = v_x - XW'(E_L);
    assign leak   = (XW'(G_L) * vdiff) >>> FRAC;
    assign dv_raw = i_x - leak - w_x;
    assign vn     = v_x + ((dvq_x * dt_x) >>> FRAC);
    assign coup   = (XW'(A) * vdiff) >>> FRAC;
    assign wn     = w_x + (((coup - w_x) * dt_x) >>> (FRAC + TAU_SHIFT));

    assign fire    = (rc_q[ch_q] == '0) && (vn >= XW'(V_TH));
    assign spk_vec = spk_acc_q | (fire ? (CHANNELS'(1) << ch_q) : '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = DV;
            DV:      state_d = UPD;
            UPD:     state_d = last_ch ? DONE : DV;
            DONE:    state_d = bus.start ? DV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Current writes are independent of the step so they can land mid-step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSLOT; k++) i_q[k] <= '0;
        end else if (bus.cur_we) begin
            i_q[bus.cur_addr] <= bus.current_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSLOT; k++) begin
                v_q[k]  <= WIDTH'(E_L);
                w_q[k]  <= '0;
                rc_q[k] <= '0;
            end
            ch_q      <= '0;
            dt_q      <= '0;
            dv_q      <= '0;
            spk_acc_q <= '0;
            spike_q   <= '0;
            dout_q    <= '0;
        end else begin
            dout_q <= v_q[bus.rd_addr];
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        dt_q      <= bus.dt;
                        ch_q      <= '0;
                        spk_acc_q <= '0;
                    end
                end
                DV: dv_q <= sat(dv_raw);
                UPD: begin
                    if (rc_q[ch_q] != '0) begin
                        v_q[ch_q]  <= WIDTH'(V_RESET);
                        w_q[ch_q]  <= sat(wn);
                        rc_q[ch_q] <= rc_q[ch_q] - RCW'(1);
                    end else if (fire) begin
                        v_q[ch_q]  <= WIDTH'(V_RESET);
                        w_q[ch_q]  <= sat(wn + XW'(B));
                        rc_q[ch_q] <= RCW'(REFRAC);
                    end else begin
                        v_q[ch_q]  <= sat(vn);
                        w_q[ch_q]  <= sat(wn);
                    end
                    spk_acc_q <= spk_vec;
                    if (last_ch) spike_q <= spk_vec;
                    ch_q <= ch_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.spike_out = spike_q;
    assign bus.busy      = (state_q == DV) || (state_q == UPD);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_hh_neuron_array.sv
// Random and directed stimulus for hh_neuron_array against a step-level behavioural model.
module tb_hh_neuron_array;
    localparam int C = 4;
    localparam longint E_L = -16640, V_TH = -12800, V_RESET = -17920;
    localparam longint G_L = 26, A = 64, B = 512, REFRAC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hh_neuron_array_if #(.WIDTH(16), .CHANNELS(C)) bus();
    hh_neuron_array dut (.clock(clk), .reset(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // One forward-Euler update of a single neuron, straight from the update rules.
    function automatic void chan_step(input longint i, v, w, rc, dt,
                                      output longint nv, nw, nrc, output bit spk);
        longint dv, vn, wn;
        dv  = sat(i - ((G_L * (v - E_L)) >>> 8) - w);
        vn  = v + ((dv * dt) >>> 8);
        wn  = w + (((((A * (v - E_L)) >>> 8) - w) * dt) >>> 12);
        spk = 1'b0;
        nrc = rc;
        if (rc != 0) begin
            nv = V_RESET; nw = sat(wn); nrc = rc - 1;
        end else if (vn >= V_TH) begin
            spk = 1'b1; nv = V_RESET; nw = sat(wn + B); nrc = REFRAC;
        end else begin
            nv = sat(vn); nw = sat(wn);
        end
    endfunction

    // Model: cnt is the cycle index within a step (0 = idle, 2C+1 = done cycle).
    longint   mV [C];
    longint   mW [C];
    longint   mI [C];
    longint   mRC [C];
    longint   mdt, isnap, e_dout;
    int       cnt;
    logic [C-1:0] acc, e_spk;

    always @(posedge clk or negedge rst_n) begin : model
        longint nv, nw, nrc;
        bit     spk;
        int     k;
        if (!rst_n) begin
            for (int j = 0; j < C; j++) begin
                mV[j] <= E_L; mW[j] <= 0; mI[j] <= 0; mRC[j] <= 0;
            end
            cnt <= 0; mdt <= 0; isnap <= 0; acc <= '0; e_spk <= '0; e_dout <= 0;
        end else begin
            e_dout <= mV[bus.rd_addr];
            if (bus.cur_we) mI[bus.cur_addr] <= longint'($signed(bus.current_in));
            if (cnt == 0 || cnt == 2*C+1) begin
                if (bus.start) begin
                    cnt <= 1; mdt <= longint'($signed(bus.dt)); acc <= '0;
                end else begin
                    cnt <= 0;
                end
            end else begin
                cnt <= cnt + 1;
                k = (cnt - 1) / 2;
                if (cnt % 2 == 1) begin
                    isnap <= mI[k];
                end else begin
                    chan_step(isnap, mV[k], mW[k], mRC[k], mdt, nv, nw, nrc, spk);
                    mV[k]  <= nv;
                    mW[k]  <= nw;
                    mRC[k] <= nrc;
                    acc    <= acc | (C'(spk) << k);
                    if (cnt == 2*C) e_spk <= acc | (C'(spk) << k);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("data_out", longint'($signed(bus.data_out)), e_dout);
        chk("busy", longint'(bus.busy), longint'(cnt >= 1 && cnt <= 2*C));
        chk("done", longint'(bus.done), longint'(cnt == 2*C+1));
        chk("spike_out", longint'(bus.spike_out), longint'(e_spk));
    end

    task automatic run_step(input logic [15:0] d, output int lat);
        @(posedge clk); #2; bus.start = 1'b1; bus.dt = d;
        @(posedge clk); #2; bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 50) begin
            @(posedge clk); #2; lat++;
        end
    endtask

    task automatic cur_write(input int ch, input logic [15:0] val);
        @(posedge clk); #2; bus.cur_we = 1'b1; bus.cur_addr = 2'(ch); bus.current_in = val;
        @(posedge clk); #2; bus.cur_we = 1'b0;
    endtask

    task automatic read_v(input int ch, output longint v);
        @(posedge clk); #2; bus.rd_addr = 2'(ch);
        @(posedge clk); #2; v = longint'($signed(bus.data_out));
    endtask

    initial begin
        int     lat, ndone;
        longint v;
        bus.start = 0; bus.dt = 0; bus.cur_we = 0; bus.cur_addr = 0;
        bus.current_in = 0; bus.rd_addr = 0;

        repeat (3) @(posedge clk);
        #2; chk("data_out_in_reset", longint'($signed(bus.data_out)), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("data_out_after_release", longint'($signed(bus.data_out)), -16640);

        run_step(16'd256, lat);
        chk("idle_step_latency", lat, 9);
        chk("idle_step_spikes", longint'(bus.spike_out), 0);
        read_v(0, v);
        chk("idle_v0", v, -16640);

        cur_write(1, 16'd256);
        run_step(16'd256, lat);
        read_v(1, v);
        chk("subthr_v1", v, -16384);
        chk("subthr_model_w1", mW[1], 0);
        read_v(2, v);
        chk("subthr_v2_rest", v, -16640);

        cur_write(2, 16'h7FFF);
        run_step(16'd256, lat);
        chk("spike_step1_flags", longint'(bus.spike_out), 4);
        chk("spike_model_w2", mW[2], 512);
        read_v(2, v);
        chk("spike_step1_v2", v, -17920);
        for (int s = 2; s <= 3; s++) begin
            run_step(16'd256, lat);
            chk("refrac_no_spike", longint'(bus.spike_out[2]), 0);
            read_v(2, v);
            chk("refrac_v2_held", v, -17920);
        end
        run_step(16'd256, lat);
        chk("spike_step4", longint'(bus.spike_out[2]), 1);

        cur_write(3, 16'h8000);
        run_step(16'h7FFF, lat);
        chk("sat_no_spike3", longint'(bus.spike_out[3]), 0);
        read_v(3, v);
        chk("sat_v3", v, -32768);

        // I[3] written during DV(0), I[0] during UPD(0), start pulsed while busy
        @(posedge clk); #2; bus.start = 1'b1; bus.dt = 16'd256;
        @(posedge clk); #2; bus.start = 1'b0;
        bus.cur_we = 1'b1; bus.cur_addr = 2'd3; bus.current_in = 16'd100;
        @(posedge clk); #2;
        bus.cur_addr = 2'd0; bus.current_in = -16'sd50;
        @(posedge clk); #2; bus.cur_we = 1'b0; bus.start = 1'b1;
        @(posedge clk); #2; bus.start = 1'b0;
        ndone = 0;
        repeat (20) begin
            if (bus.done) ndone++;
            @(posedge clk); #2;
        end
        chk("start_while_busy_single_done", ndone, 1);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            bus.start   = ($urandom % 8) == 0;
            bus.dt      = 16'($urandom_range(0, 600));
            bus.cur_we  = ($urandom % 4) == 0;
            bus.cur_addr = 2'($urandom);
            bus.current_in = (($urandom % 10) == 0) ? 16'($urandom)
                                                    : 16'(int'($urandom_range(0, 6000)) - 2000);
            bus.rd_addr = 2'($urandom);
        end
        bus.start = 0; bus.cur_we = 0;
        repeat (12) @(posedge clk);

        @(posedge clk); #2; bus.start = 1'b1; bus.dt = 16'd256; bus.rd_addr = 0;
        @(posedge clk); #2; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_done", longint'(bus.done), 0);
        chk("midrst_data_out", longint'($signed(bus.data_out)), 0);
        chk("midrst_spike_out", longint'(bus.spike_out), 0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #2;
            if (bus.done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        rst_n = 1'b1;
        run_step(16'd256, lat);
        chk("after_rst_latency", lat, 9);
        chk("after_rst_spikes", longint'(bus.spike_out), 0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hh_neuron_array.md
# hh_neuron_array

Parametrised, time-multiplexed array of linearised Hodgkin-Huxley neuron channels. Each channel holds a membrane potential V and a lumped recovery variable w. The block integrates all channels with a forward-Euler step on each `start` pulse, using a per-channel input current and a global `dt`. It adds threshold spike detection, reset-after-spike, w adaptation and a refractory period. It generalises the single-neuron linear HH top-level to CHANNELS neurons that share one arithmetic datapath.

## Interface
- WIDTH, 16: signed fixed-point word width for V, w, I and dt.
- FRAC, 8: fractional bits (default Q8.8).
- CHANNELS, 4: number of neurons (≥1); index width AW = max(1, clog2(CHANNELS)).
- E_L, -16640: leak reversal / rest potential (-65.0).
- V_TH, -12800: spike threshold (-50.0).
- V_RESET, -17920: post-spike potential (-70.0).
- G_L, 26: leak conductance (≈0.1).
- A, 64: subthreshold coupling of w to V (0.25).
- B, 512: spike-triggered w increment (2.0).
- TAU_SHIFT, 4: w time constant = 2^TAU_SHIFT.
- REFRAC, 2: refractory length in integration steps.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one integration step of all channels.
- dt  in  WIDTH  signed time step; sampled on accepted `start`.
- cur_we  in  1  current-register write enable.
- cur_addr  in  AW  channel for the current write.
- current_in  in  WIDTH  signed input current I.
- rd_addr  in  AW  channel shown on `data_out`.
- data_out  out  WIDTH  registered V of channel `rd_addr`.
- spike_out  out  CHANNELS  per-channel spike flags, pulsed with `done`.
- busy  out  1  step in progress.
- done  out  1  one-cycle pulse at step completion.

## Operation
- Per-channel state: V, w, I, refractory counter rc.
- Reset (asynchronous, while `reset`=0) sets:
  - V=E_L, w=0, I=0, rc=0.
  - FSM to IDLE.
  - `data_out`=0, `spike_out`=0, `busy`=0, `done`=0.
- `cur_we`=1 writes `current_in` to I[cur_addr] at the clock edge. Writes are allowed in any state.
- FSM states: IDLE, DV, UPD, DONE.
  - IDLE → DV(ch 0) on `start`=1. `dt` is latched and `busy` is set.
  - DV(k): compute dV = I[k] − ((G_L·(V[k]−E_L))>>>FRAC) − w[k], saturated to WIDTH.
  - UPD(k): write V[k], w[k] and rc[k] (rules below). Then go to DV(k+1), or to DONE after k=CHANNELS−1.
  - DONE: `done`=1, `spike_out` holds this step's flags, `busy` clears. Then → IDLE.
- UPD rules, all using the old V[k] and w[k]:
  - Vn = V + ((dV·dt)>>>FRAC).
  - wn = w + (((A·(V−E_L))>>>FRAC − w)·dt >>> (FRAC+TAU_SHIFT)).
  - If rc≠0: V=V_RESET, w=wn, rc=rc−1, no spike.
  - Else if Vn ≥ V_TH: spike flag k=1, V=V_RESET, w=sat(wn+B), rc=REFRAC.
  - Else: V=Vn, w=wn.
- Arithmetic:
  - Products are full 2·WIDTH signed.
  - `>>>` is an arithmetic shift.
  - Every stored result saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; no wrap-around.
- `start` while `busy`=1 is ignored, not queued.
- A current write to channel k lands before DV(k) → used this step; lands at or after DV(k) → used next step.
- `data_out` is registered every cycle from V[rd_addr], so it reflects in-step updates.
- `spike_out` updates only in DONE, holds its value until the next DONE, and clears at reset.

## Timing
- Accepted `start` at edge t: `busy`=1 from t+1.
- Channel k is processed in DV at t+1+2k and UPD at t+2+2k.
- `done`=1 in cycle t+2·CHANNELS+1 and `busy`=0 in that same cycle.
- Next `start` is accepted at the edge ending DONE at the earliest.
- `data_out` lags a V write by 1 cycle.
- Reset asserted mid-step aborts the step immediately: all state returns to reset values and no `done` is issued.

## Test plan
- Reset then idle: `data_out`=0 during reset and −16640 (0xBF00) one cycle after release with rd_addr=0. Then `start` with dt=256 and I=0: V stays 0xBF00, w=0, `done` arrives exactly 9 cycles after `start`, `spike_out`=0.
- Subthreshold drive: I[1]=256, dt=256, one step → V[1]=−16384 (0xC000), w[1]=0. Other channels stay at 0xBF00.
- Spike and refractory: I[2]=0x7FFF, dt=256:
  - Step 1 → `spike_out`=4'b0100, V[2]=−17920, w[2]=512.
  - Steps 2–3 → V[2] held at −17920, no spike.
  - Step 4 → spikes again.
- Saturation: I[3]=−32768, dt=0x7FFF → V[3]=−32768 (0x8000), no spike, no wrap.
- Handshake edges:
  - `start` pulsed while `busy` → ignored, exactly one `done`.
  - I[3] written during DV(0) → used in the same step.
  - I[0] written during UPD(0) → used in the next step.
- Reset mid-step (cycle 4 of a step): all outputs return to reset values immediately, no `done`. A fresh `start` after release completes normally in 9 cycles.
